// File: rtl/array_mult_pipe_if.sv
// Operand/product handshake bundle for array_mult_pipe.
// The operand source and the product sink both use the master side.
interface array_mult_pipe_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   in_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_p;
    logic                   out_signed;
    logic                   busy;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p, out_signed, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p, out_signed, busy
    );
endinterface

// File: rtl/array_mult_pipe.sv
// Pipelined Baugh-Wooley array multiplier. Level 0 registers the operands, and
// levels 1..STAGES each add ROWS_PER_STAGE partial-product rows into a running sum.
module array_mult_pipe #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2,
    parameter int APPROX_COLS    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    array_mult_pipe_if.slave  bus
);
    localparam int PW     = 2 * WIDTH;
    localparam int STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    // Builds row i, already shifted into place. Sign inversion is applied before truncation.
    function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sgn,
                                             input int               i);
        logic [PW-1:0]    row;
        logic [WIDTH-1:0] a_sh;
        logic [WIDTH-1:0] b_sh;
        logic             bit_v;
        row  = '0;
        b_sh = b >> i;
        for (int j = 0; j < WIDTH; j++) begin
            a_sh  = a >> j;
            bit_v = a_sh[0] & b_sh[0];
            if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                bit_v = ~bit_v;
            end else begin
                bit_v = bit_v;
            end
            if (i + j < APPROX_COLS) begin
                bit_v = 1'b0;
            end else begin
                bit_v = bit_v;
            end
            row = row | (PW'(bit_v) << (i + j));
        end
        return row;
    endfunction

    logic [STAGES:0]   valid_q, valid_d;
    logic [STAGES:0]   sgn_q,   sgn_d;
    logic [PW-1:0]     sum_q [0:STAGES];
    logic [PW-1:0]     sum_d [0:STAGES];
    logic [WIDTH-1:0]  a_q   [0:STAGES-1];
    logic [WIDTH-1:0]  a_d   [0:STAGES-1];
    logic [WIDTH-1:0]  b_q   [0:STAGES-1];
    logic [WIDTH-1:0]  b_d   [0:STAGES-1];
    logic [PW-1:0]     acc_s;
    logic              advance_s;

    assign bus.in_ready   = advance_s;
    assign bus.out_valid  = valid_q[STAGES];
    assign bus.out_p      = sum_q[STAGES];
    assign bus.out_signed = sgn_q[STAGES];
    assign bus.busy       = |valid_q;

    // Next-state of every level: shift by one when the output can move, else hold.
    always_comb begin
        advance_s = ~valid_q[STAGES] | bus.out_ready;
        valid_d   = valid_q;
        sgn_d     = sgn_q;
        sum_d     = sum_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_s     = '0;
        if (advance_s) begin
            valid_d[0] = bus.in_valid;
            sgn_d[0]   = bus.in_signed;
            a_d[0]     = bus.in_a;
            b_d[0]     = bus.in_b;
            // The Baugh-Wooley correction constant is seeded up front so later stages only add rows.
            sum_d[0]   = bus.in_signed ? BW_CONST : '0;
            for (int k = 1; k <= STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                sgn_d[k]   = sgn_q[k-1];
                acc_s      = sum_q[k-1];
                for (int r = 0; r < ROWS_PER_STAGE; r++) begin
                    if ((k - 1) * ROWS_PER_STAGE + r < WIDTH) begin
                        acc_s = acc_s + pp_row(a_q[k-1], b_q[k-1], sgn_q[k-1],
                                               (k - 1) * ROWS_PER_STAGE + r);
                    end else begin
                        acc_s = acc_s;
                    end
                end
                sum_d[k] = acc_s;
            end
            for (int k = 1; k < STAGES; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
            end
        end else begin
            valid_d = valid_q;
            sum_d   = sum_q;
        end
    end

    // Pipeline registers; reset discards every operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sgn_q   <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                sum_q[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sgn_q   <= sgn_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
endmodule

// File: tb/tb_array_mult_pipe.sv
// Directed and scoreboarded checks of array_mult_pipe (exact instance) plus a
// truncating instance with APPROX_COLS=4.
module tb_array_mult_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    array_mult_pipe_if #(.WIDTH(8)) bus ();
    array_mult_pipe_if #(.WIDTH(8)) bus2 ();

    array_mult_pipe #(.WIDTH(8), .ROWS_PER_STAGE(2), .APPROX_COLS(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    array_mult_pipe #(.WIDTH(8), .ROWS_PER_STAGE(2), .APPROX_COLS(4)) dut_apx (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int          n_checks = 0;
    int          n_errors = 0;
    int          tick_cnt = 0;
    logic [15:0] q_p [$];
    logic        q_s [$];
    logic [15:0] cur_p;
    logic        cur_s;
    logic        acc_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] x;
        logic signed [15:0] y;
        x = $signed({{8{a[7]}}, a});
        y = $signed({{8{b[7]}}, b});
        if (s) return 16'(x * y);
        else   return 16'({8'h00, a} * {8'h00, b});
    endfunction

    task automatic tick();
        #1;
        if (bus.in_valid && bus.in_ready) begin
            q_p.push_back(cur_p);
            q_s.push_back(cur_s);
            acc_flag = 1'b1;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q_p.size() == 0) begin
                chk("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("prod", 32'(bus.out_p), 32'(q_p[0]));
                chk("out_signed", 32'(bus.out_signed), 32'(q_s[0]));
                void'(q_p.pop_front());
                void'(q_s.pop_front());
            end
        end
        @(posedge clk);
        #1;
        tick_cnt++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        cur_p         = e;
        cur_s         = s;
        acc_flag      = 1'b0;
        for (int t = 0; t < 20 && !acc_flag; t++) tick();
        if (!acc_flag) chk("accept_timeout", 32'(acc_flag), 32'd1);
    endtask

    task automatic drain(output int n);
        n = 0;
        while (q_p.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(q_p.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t0;
        int seen;
        logic [7:0] ra, rb;
        logic       rs;

        bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_signed = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = 8'h00; bus2.in_b = 8'h00; bus2.in_signed = 1'b0;
        bus2.out_ready = 1'b1;
        cur_p = 16'h0000; cur_s = 1'b0; acc_flag = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_p", 32'(bus.out_p), 32'd0);
        chk("rst_out_signed", 32'(bus.out_signed), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: latency and basic unsigned products
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t1_latency_valid", 32'(bus.out_valid), 32'(i == 4));
        end
        chk("t1_p_ff_ff", 32'(bus.out_p), 32'h0000FE01);
        send(8'h00, 8'hAB, 1'b0, 16'h0000);
        bus.in_valid = 1'b0;
        drain(n);

        // 2: signed corners and back-to-back mode change
        send(8'h80, 8'h80, 1'b1, 16'h4000);
        send(8'hFF, 8'h01, 1'b1, 16'hFFFF);
        send(8'hFF, 8'h01, 1'b0, 16'h00FF);
        bus.in_valid = 1'b0;
        drain(n);

        // 3: full-rate random stream
        t0 = tick_cnt;
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, ref_mul(ra, rb, rs));
        end
        bus.in_valid = 1'b0;
        chk("t3_accept_cycles", 32'(tick_cnt - t0), 32'd16);
        drain(n);
        chk("t3_drain_cycles", 32'(n), 32'd5);

        // 4: back-pressure with a full pipe
        bus.out_ready = 1'b0;
        t0 = tick_cnt;
        send(8'h03, 8'h05, 1'b0, 16'h000F);
        send(8'h10, 8'h10, 1'b0, 16'h0100);
        send(8'hFE, 8'h02, 1'b1, 16'hFFFC);
        send(8'h7F, 8'h7F, 1'b0, 16'h3F01);
        send(8'hC8, 8'h64, 1'b0, 16'h4E20);
        chk("t4_fill_cycles", 32'(tick_cnt - t0), 32'd5);
        bus.in_a = 8'h0A; bus.in_b = 8'h0B; bus.in_signed = 1'b1;
        cur_p = 16'h006E; cur_s = 1'b1; acc_flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
            chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_out_p_held", 32'(bus.out_p), 32'h0000000F);
        end
        chk("t4_no_accept", 32'(acc_flag), 32'd0);
        bus.out_ready = 1'b1;
        for (int t = 0; t < 20 && !acc_flag; t++) tick();
        chk("t4_accept_after_stall", 32'(acc_flag), 32'd1);
        bus.in_valid = 1'b0;
        drain(n);

        // 5: reset mid-stream
        for (int i = 0; i < 3; i++) send(8'(i + 3), 8'(i + 7), 1'b0, ref_mul(8'(i + 3), 8'(i + 7), 1'b0));
        bus.in_valid = 1'b0;
        chk("t5_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
        q_p.delete();
        q_s.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen += int'(bus.out_valid) + int'(bus.busy);
        end
        chk("t5_no_stale", 32'(seen), 32'd0);

        // 6: truncating instance
        bus2.in_valid = 1'b1; bus2.in_a = 8'h0F; bus2.in_b = 8'h0F; bus2.in_signed = 1'b0;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_early_valid", 32'(bus2.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t6_valid_a", 32'(bus2.out_valid), 32'd1);
        chk("t6_p_0f_0f", 32'(bus2.out_p), 32'h000000B0);
        bus2.in_valid = 1'b1; bus2.in_a = 8'hF0; bus2.in_b = 8'h01;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_valid_b", 32'(bus2.out_valid), 32'd1);
        chk("t6_p_f0_01", 32'(bus2.out_p), 32'h000000F0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
